// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction classes and step encoding shared by the control unit and its bench.
package cpu_pkg;
  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3,
    OP_SUB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6, OP_ROR = 5'd7, OP_ROL = 5'd8, OP_SHR = 5'd9,
    OP_SHRA = 5'd10, OP_SHL = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI = 5'd14,
    OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BRX = 5'd19,
    OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23, OP_MFHI = 5'd24,
    OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  typedef enum logic [3:0] {
    ALU3, ALUI, LD, ST, MULDIV, UNARY, BR, JR, JAL, MOVE, IO, NOP, HALT
  } cls_t;
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;
  function automatic step_t last_step(input cls_t c);
    case (c)
      ALU3, ALUI: last_step = T5;
      LD, ST: last_step = T7;
      MULDIV, BR: last_step = T6;
      UNARY, JAL: last_step = T4;
      JR, MOVE, IO: last_step = T3;
      default: last_step = T2;
    endcase
  endfunction
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: maps an opcode to its execution class; in/out decode as IO only with CTRL_IO_EN.
module instr_class_decode
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opc,
  output cls_t            cls
);
  always_comb
    case (opc)
      OP_LD: cls = LD;
      OP_ST: cls = ST;
      OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: cls = ALUI;
      OP_MUL, OP_DIV: cls = MULDIV;
      OP_NEG, OP_NOT: cls = UNARY;
      OP_BRX: cls = BR;
      OP_JR: cls = JR;
      OP_JAL: cls = JAL;
      OP_MFHI, OP_MFLO: cls = MOVE;
`ifdef CTRL_IO_EN
      OP_IN, OP_OUT: cls = IO;
`endif
      OP_HALT: cls = HALT;
      default: cls = (opc >= OP_ADD && opc <= OP_SHL) ? ALU3 : NOP;
    endcase
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired T0..T7 control unit decoding datapath strobes from step and IR.
// Optional in/out instructions are enabled by defining CTRL_IO_EN.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int STEP_W = 3,
  parameter int OPC_W  = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      IR,
  input  logic             con_ff,
  output logic             PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out,
  output logic             MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable,
  output logic             HI_enable, LO_enable, CON_enable, out_port_enable,
  output logic             IncPC, Read, RAM_write_enable,
  output logic             Gra, Grb, Grc, R_in, R_out, BA_out, link_sel,
  output logic [OPC_W-1:0] opcode,
  output logic             run
);
  logic [STEP_W-1:0] step, step_nx;
  logic active, halted, halted_nx, done;
  logic [OPC_W-1:0] opc, imm_op;
  logic unused_ir;
  cls_t cls;
  assign opc = IR[31 -: OPC_W];
  assign unused_ir = ^IR[31-OPC_W:0];
  assign run = active && !halted;
  assign imm_op = opc == OP_ANDI ? OP_AND : opc == OP_ORI ? OP_OR : OP_ADD;
  instr_class_decode u_dec (.opc(opc), .cls(cls));
  // active distinguishes the reset-pending state from T0 so run stays low until the first edge
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      step <= '0;
      active <= 1'b0;
      halted <= 1'b0;
    end else begin
      step <= step_nx;
      active <= 1'b1;
      halted <= halted_nx;
    end
  always_comb begin
    done = step == last_step(cls) || step == T7;
    step_nx = (!active || halted || done) ? '0 : step + STEP_W'(1);
    halted_nx = halted || (active && step == T2 && cls == HALT);
  end
  always_comb begin
    {PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out} = '0;
    {MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable} = '0;
    {HI_enable, LO_enable, CON_enable, out_port_enable} = '0;
    {IncPC, Read, RAM_write_enable, Gra, Grb, Grc, R_in, R_out, BA_out, link_sel} = '0;
    opcode = '0;
    if (run)
      case (step)
        T0: {PC_out, MAR_enable, IncPC, PC_enable} = '1;
        T1: {Read, MDR_enable} = '1;
        T2: {MDR_out, IR_enable} = '1;
        default:
          case (cls)
            ALU3:
              if (step == T3) {Grb, R_out, Y_enable} = '1;
              else if (step == T4) begin
                {Grc, R_out, Z_enable} = '1;
                opcode = opc;
              end else if (step == T5) {ZLow_out, Gra, R_in} = '1;
            // ld/st compute the effective address exactly like ldi before the memory steps
            ALUI, LD, ST:
              if (step == T3) {Grb, BA_out, Y_enable} = '1;
              else if (step == T4) begin
                {C_out, Z_enable} = '1;
                opcode = imm_op;
              end else if (step == T5) begin
                ZLow_out = 1'b1;
                if (cls == ALUI) {Gra, R_in} = '1;
                else MAR_enable = 1'b1;
              end else if (step == T6) begin
                MDR_enable = 1'b1;
                if (cls == LD) Read = 1'b1;
                else {Gra, R_out} = '1;
              end else if (step == T7) begin
                if (cls == LD) {MDR_out, Gra, R_in} = '1;
                else RAM_write_enable = 1'b1;
              end
            MULDIV:
              if (step == T3) {Gra, R_out, Y_enable} = '1;
              else if (step == T4) begin
                {Grb, R_out, Z_enable} = '1;
                opcode = opc;
              end else if (step == T5) {ZLow_out, LO_enable} = '1;
              else if (step == T6) {ZHigh_out, HI_enable} = '1;
            UNARY:
              if (step == T3) begin
                {Grb, R_out, Z_enable} = '1;
                opcode = opc;
              end else if (step == T4) {ZLow_out, Gra, R_in} = '1;
            BR:
              if (step == T3) {Gra, R_out, CON_enable} = '1;
              else if (step == T4) {PC_out, Y_enable} = '1;
              else if (step == T5) begin
                {C_out, Z_enable} = '1;
                opcode = OP_ADD;
              end else if (step == T6 && con_ff) {ZLow_out, PC_enable} = '1;
            JR: if (step == T3) {Gra, R_out, PC_enable} = '1;
            JAL:
              if (step == T3) {PC_out, link_sel, R_in} = '1;
              else if (step == T4) {Gra, R_out, PC_enable} = '1;
            MOVE:
              if (step == T3) begin
                {Gra, R_in} = '1;
                if (opc == OP_MFHI) HI_out = 1'b1;
                else LO_out = 1'b1;
              end
`ifdef CTRL_IO_EN
            IO:
              if (step == T3) begin
                if (opc == OP_IN) {In_port_out, Gra, R_in} = '1;
                else {Gra, R_out, out_port_enable} = '1;
              end
`endif
            default: ;
          endcase
      endcase
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the datapath's bus-drive, register-enable, memory and ALU-select strobes one clock step at a time. It replaces hand-sequenced stimulus with a real T0..T7 state machine. Each step's strobes are decoded from the step counter and the instruction register. It sits beside the Datapath: its outputs connect to the Datapath's like-named control inputs, and the Datapath returns IR and the branch condition flip-flop.

## Interface
Parameters:
- STEP_W, 3, width of the step counter (T0..T7)
- OPC_W, 5, width of the opcode field IR[31:27] and of the ALU select

Ports (clock and reset first). One clock; reset is asynchronous and active-high.
- clk  in  1  single system clock, rising edge
- clr  in  1  asynchronous, active-high reset
- IR  in  32  instruction register contents from the Datapath
- con_ff  in  1  branch condition flip-flop from the Datapath
- PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out  out  1 each  bus drivers, at most one high per step
- MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable, PC_enable, HI_enable, LO_enable, CON_enable, out_port_enable  out  1 each  register loads
- IncPC, Read, RAM_write_enable  out  1 each  PC increment, memory read, memory write
- Gra, Grb, Grc, R_in, R_out, BA_out, link_sel  out  1 each  select-and-encode controls; link_sel forces the R15 enable
- opcode  out  5  ALU operation select
- run  out  1  high while executing, low in reset and after halt

## Operation
- Fetch, common to all instructions:
  - T0: PC_out, MAR_enable, IncPC, PC_enable
  - T1: Read, MDR_enable
  - T2: MDR_out, IR_enable
- Execute steps start at T3 and are decoded from IR[31:27]. After the last step of an instruction, the next step is T0.
- 3-operand ALU (add 00011 … shl 01011):
  - T3: Grb, R_out, Y_enable
  - T4: Grc, R_out, Z_enable, opcode=IR[31:27]
  - T5: ZLow_out, Gra, R_in
- Immediate ALU (addi 01100, andi 01101, ori 01110) and ldi 00001:
  - T3: Grb, BA_out, Y_enable
  - T4: C_out, Z_enable, opcode = add for addi/ldi, and for andi, or for ori
  - T5: ZLow_out, Gra, R_in
- ld 00000 and st 00010:
  - T3, T4: same as ldi
  - T5: ZLow_out, MAR_enable
  - ld T6: Read, MDR_enable. ld T7: MDR_out, Gra, R_in
  - st T6: Gra, R_out, MDR_enable (Read low selects the bus). st T7: RAM_write_enable
- mul 01111 and div 10000:
  - T3: Gra, R_out, Y_enable
  - T4: Grb, R_out, Z_enable, opcode=IR op
  - T5: ZLow_out, LO_enable
  - T6: ZHigh_out, HI_enable
- neg 10001 and not 10010:
  - T3: Grb, R_out, Z_enable, opcode=IR op
  - T4: ZLow_out, Gra, R_in
- brx 10011:
  - T3: Gra, R_out, CON_enable
  - T4: PC_out, Y_enable
  - T5: C_out, Z_enable, opcode=add
  - T6: if con_ff, ZLow_out and PC_enable; otherwise no strobes
- jr 10100: T3: Gra, R_out, PC_enable
- jal 10101:
  - T3: PC_out, link_sel, R_in
  - T4: Gra, R_out, PC_enable
- mfhi 11000 and mflo 11001: T3: HI_out (or LO_out), Gra, R_in
- nop 11010, and every undefined opcode 11100-11111: return to T0 after T2. T3 is skipped.
- halt 11011: enter HALTED after T2. run=0. All strobes stay 0 until clr.

## Timing
- Outputs are combinational from the step register, the halted flag and IR. Each strobe is held for the whole step, and loads take effect on the rising edge that ends that step.
- While clr is high, step=T0-pending (RST): all outputs 0, opcode=0, run=0.
- The first rising edge after clr falls enters T0 with run=1.
- Latency in clocks, fetch included:
  - nop: 3
  - jr, mfhi, mflo, in, out: 4
  - neg, not, jal: 5
  - ALU, immediate ALU, ldi: 6
  - mul, div, brx: 7
  - ld, st: 8
- clr asserted mid-instruction clears state and outputs immediately. The partially executed instruction is abandoned.
- The step counter never passes T7. A decode that is still active at T7 forces a return to T0.

## Configuration
- CTRL_IO_EN defined:
  - in 10110: T3 drives In_port_out, Gra, R_in
  - out 10111: T3 drives Gra, R_out, out_port_enable
- CTRL_IO_EN undefined: in and out decode as nop, and In_port_out and out_port_enable are tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams for all 28 instructions
  - the instruction-class enum (ALU3, ALUI, LD, ST, MULDIV, UNARY, BR, JR, JAL, MOVE, IO, NOP, HALT)
  - the step enum T0..T7
- One sub-module, instr_class_decode, maps IR[31:27] to the class. It is purely combinational and shared with the bench's checker.

## Test plan
- Reset release: clr=1 for 2 cycles, then 0 → all outputs 0 and run=0 during reset. Cycle 1 after release shows PC_out=MAR_enable=IncPC=PC_enable=1.
- IR=0x18918000 (add R1,R2,R3) → 6-step sequence in which T4 shows opcode=00011 and T5 shows ZLow_out, Gra and R_in. The next cycle is T0.
- IR=0x01000055 (ld R2,0x55(R0)) → T5 has MAR_enable, T6 has Read with MDR_enable, T7 has MDR_out with Gra and R_in. 8 cycles total.
- IR=0x98000000 (brx) with con_ff=0 → T6 shows no PC_enable. With con_ff=1 → T6 shows ZLow_out and PC_enable.
- IR=0xD8000000 (halt) → run falls after T2 and all strobes stay 0 for 20 cycles. Pulsing clr resumes fetch at T0.
- Assert clr during T4 of mul (IR=0x78800000) → outputs go to 0 in the same cycle, LO_enable and HI_enable are never seen, and fetch restarts at T0.
